banked_mem_ctrl: RTL



---
 rtl/banked_mem_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/banked_mem_ctrl.sv
// rtl/banked_mem_ctrl.sv - multi-bank SRAM controller with per-bank recovery and fixed-latency reads
module banked_mem_ctrl #(
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 8,
    parameter int DATA_W     = 8,
    parameter int RECOVERY   = 1,
    localparam int BANK_W    = $clog2(NUM_BANKS),
    localparam int IDX_W     = $clog2(BANK_DEPTH),
    localparam int ADDR_W    = BANK_W + IDX_W,
    localparam int STRB_W    = DATA_W / 8
) (
    input  logic              clk_pi,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [STRB_W-1:0] req_wstrb_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic [BANK_W-1:0] rsp_bank_o,
    output logic [15:0]       stall_cnt_o
);

    localparam logic [2:0] REC = 3'(RECOVERY);

    logic [BANK_W-1:0] req_bank;
    logic [IDX_W-1:0]  req_idx;
    logic              accept;

    logic [2:0] busy_q [NUM_BANKS];
    logic [2:0] busy_d [NUM_BANKS];

    logic              s1_valid_q;
    logic              s1_we_q;
    logic [BANK_W-1:0] s1_bank_q;
    logic [IDX_W-1:0]  s1_idx_q;
    logic [DATA_W-1:0] s1_wdata_q;
    logic [STRB_W-1:0] s1_wstrb_q;

    logic [DATA_W-1:0] mem_q [NUM_BANKS][BANK_DEPTH];

    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [BANK_W-1:0] rsp_bank_q, rsp_bank_d;
    logic [15:0]       stall_q, stall_d;

    assign req_bank    = req_addr_i[ADDR_W-1:IDX_W];
    assign req_idx     = req_addr_i[IDX_W-1:0];
    assign req_ready_o = rst_ni & (busy_q[req_bank] == 3'd0);
    assign accept      = req_valid_i & req_ready_o;

    // The accepted bank reloads its recovery window; every other bank keeps draining.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            busy_d[b] = (busy_q[b] != 3'd0) ? busy_q[b] - 3'd1 : 3'd0;
            if (accept && (req_bank == BANK_W'(b))) begin
                busy_d[b] = REC;
            end
        end
    end

    always_ff @(posedge clk_pi) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            busy_q[b] <= rst_ni ? busy_d[b] : 3'd0;
        end
    end

    always_ff @(posedge clk_pi) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= accept;
        end
        if (accept) begin
            s1_we_q    <= req_we_i;
            s1_bank_q  <= req_bank;
            s1_idx_q   <= req_idx;
            s1_wdata_q <= req_wdata_i;
            s1_wstrb_q <= req_wstrb_i;
        end
    end

    // Commit is gated by reset so a request caught in S1 by reset never lands.
    always_ff @(posedge clk_pi) begin
        if (rst_ni && s1_valid_q && s1_we_q) begin
            for (int j = 0; j < STRB_W; j++) begin
                if (s1_wstrb_q[j]) begin
                    mem_q[s1_bank_q][s1_idx_q][8*j +: 8] <= s1_wdata_q[8*j +: 8];
                end
            end
        end
    end

    always_comb begin
        rsp_valid_d = s1_valid_q & ~s1_we_q;
        rsp_rdata_d = '0;
        rsp_bank_d  = '0;
        if (rsp_valid_d) begin
            rsp_rdata_d = mem_q[s1_bank_q][s1_idx_q];
            rsp_bank_d  = s1_bank_q;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (req_valid_i && !req_ready_o && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk_pi) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_bank_q  <= '0;
            stall_q     <= 16'd0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_bank_q  <= rsp_bank_d;
            stall_q     <= stall_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_bank_o  = rsp_bank_q;
    assign stall_cnt_o = stall_q;

endmodule
